global_buffer_mr_ctrl: RTL
==========================

GLOBAL_BUFFER_MR_CTRL -- requirements
Module: global_buffer_mr_ctrl

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL have parameter DATA_W, 32, width of one RAM word and of every data bus.
REQ-002 SHALL have parameter DEPTH, 1024, number of RAM words.
REQ-003 SHALL have parameter ADDR_W, $clog2(DEPTH), RAM word-address width.
REQ-004 SHALL have parameter NUM_REGIONS, 4, number of independent buffer regions; must be at least 2.
REQ-005 SHALL have parameter LEN_W, 16, width of the command burst length.

Ports, one per line: name, direction, width, meaning. RW = $clog2(NUM_REGIONS).
REQ-006 SHALL have clk, in, 1, the only clock; all logic is rising-edge.
REQ-007 SHALL have rst, in, 1, asynchronous active-high reset.
REQ-008 SHALL have cmd_valid_i / cmd_ready_o, in / out, 1 each, command handshake.
REQ-009 SHALL have cmd_op_i, in, 2, operation: 0 WR_EXT, 1 WR_OBUF, 2 READ, 3 PTR_RESET.
REQ-010 SHALL have cmd_region_i, in, RW, target region; cmd_len_i, in, LEN_W, burst length in words.
REQ-011 SHALL have cfg_base_i, in, NUM_REGIONS*ADDR_W, region base addresses; cfg_size_i, in, NUM_REGIONS*(ADDR_W+1), region sizes in words.
REQ-012 SHALL have ext_wr_data_i / ext_wr_valid_i / ext_wr_ready_o, in DATA_W / in 1 / out 1, external write stream.
REQ-013 SHALL have obuf_wr_data_i / obuf_wr_valid_i / obuf_wr_ready_o, in DATA_W / in 1 / out 1, writeback stream.
REQ-014 SHALL have rd_data_o / rd_valid_o / rd_ready_i, out DATA_W / out 1 / in 1, read stream.
REQ-015 SHALL have ram_wr_en_o, ram_rd_en_o, out, 1 each; ram_addr_o, out, ADDR_W; ram_wr_data_o, out, DATA_W; ram_rd_data_i, in, DATA_W; RAM read latency is exactly 1 cycle.
REQ-016 SHALL have busy_o, out, 1, command active; done_o, out, 1, one-cycle pulse when a command completes.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, DRAIN; cmd_ready_o is 1 only in IDLE.
REQ-018 SHALL, on command accept in IDLE, latch op, region and len; go to WRITE for WR_EXT/WR_OBUF or READ for READ; len 0 stays in IDLE and pulses done_o on the next cycle.
REQ-019 SHALL handle PTR_RESET by zeroing the selected region's write and read heads in 1 cycle, staying in IDLE, and pulsing done_o on the next cycle.
REQ-020 SHALL keep, per region, a write head and a read head, each ADDR_W bits and relative to that region's base.
REQ-021 SHALL drive ram_addr_o = (base + head) mod DEPTH.
REQ-022 SHALL wrap a head to 0 when its increment equals the region size; size 0 is treated as DEPTH.
REQ-023 SHALL, in WRITE, drive the selected source's ready = 1 and the other source's ready = 0; each valid&&ready beat asserts ram_wr_en_o, writes the data, and increments the write head.
REQ-024 SHALL leave WRITE to IDLE after the len-th beat, pulsing done_o in the same cycle as that beat.
REQ-025 SHALL, in READ, issue ram_rd_en_o only when output-FIFO occupancy + in-flight reads < 2; each issue increments the read head.
REQ-026 SHALL capture ram_rd_data_i into a 2-entry output FIFO one cycle after the issue; rd_valid_o = FIFO non-empty, and the head pops on rd_valid_o&&rd_ready_i.
REQ-027 SHALL produce back-to-back read beats (1 per cycle) when rd_ready_i is held 1.
REQ-028 SHALL move from READ to DRAIN after the len-th issue, and from DRAIN to IDLE when the last beat pops, pulsing done_o in that cycle.
REQ-029 SHALL preserve region heads across commands; the read head is independent of the write head, so a READ needs no preceding PTR_RESET.
REQ-030 SHALL ignore cmd_* while not in IDLE, and SHALL never assert ram_wr_en_o and ram_rd_en_o in the same cycle.
REQ-031 SHALL sample cfg_* only at command accept; changes mid-command have no effect.

Reset
REQ-032 SHALL, while rst = 1, force: FSM to IDLE; all heads to 0; FIFO empty; in-flight count 0.
REQ-033 SHALL, while rst = 1, hold all outputs at 0 except cmd_ready_o = 1.
REQ-034 SHALL abort any command on reset mid-operation, with no done_o pulse.

Verification
REQ-035 SHALL cover: region 1 base 100 size 8, WR_EXT len 4 with data 0xA0..0xA3 -> RAM writes to addr 100..103, done_o on the 4th beat.
REQ-036 SHALL cover: READ len 4 on that region with rd_ready_i = 1 -> 0xA0..0xA3 on consecutive cycles, first beat 2 cycles after accept.
REQ-037 SHALL cover wrap: base 1020, size 8, WR_OBUF len 10 -> addrs 1020..1023, 0..3, then 1020, 1021.
REQ-038 SHALL cover backpressure: READ len 6 with rd_ready_i toggling every cycle -> no beat lost or duplicated, and never more than 2 outstanding.
REQ-039 SHALL cover: PTR_RESET of region 2 while region 1 heads are 5 -> region 2 heads 0, region 1 heads unchanged.
REQ-040 SHALL cover: rst asserted mid-READ -> outputs 0, cmd_ready_o = 1, no done_o, all heads 0.

Source files
------------

// File: rtl/global_buffer_mr_ctrl.sv
// Multi-region global buffer controller: per-region circular write/read heads
// over one shared single-port RAM, with a 2-entry read-out FIFO.
`timescale 1ns/1ps
module global_buffer_mr_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int NUM_REGIONS = 4,
    parameter int LEN_W       = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid_i,
    output logic                                cmd_ready_o,
    input  logic [1:0]                          cmd_op_i,
    input  logic [$clog2(NUM_REGIONS)-1:0]      cmd_region_i,
    input  logic [LEN_W-1:0]                    cmd_len_i,
    input  logic [NUM_REGIONS*ADDR_W-1:0]       cfg_base_i,
    input  logic [NUM_REGIONS*(ADDR_W+1)-1:0]   cfg_size_i,
    input  logic [DATA_W-1:0]                   ext_wr_data_i,
    input  logic                                ext_wr_valid_i,
    output logic                                ext_wr_ready_o,
    input  logic [DATA_W-1:0]                   obuf_wr_data_i,
    input  logic                                obuf_wr_valid_i,
    output logic                                obuf_wr_ready_o,
    output logic [DATA_W-1:0]                   rd_data_o,
    output logic                                rd_valid_o,
    input  logic                                rd_ready_i,
    output logic                                ram_wr_en_o,
    output logic                                ram_rd_en_o,
    output logic [ADDR_W-1:0]                   ram_addr_o,
    output logic [DATA_W-1:0]                   ram_wr_data_o,
    input  logic [DATA_W-1:0]                   ram_rd_data_i,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int RW = $clog2(NUM_REGIONS);
    localparam logic [1:0] OP_WR_EXT  = 2'd0;
    localparam logic [1:0] OP_WR_OBUF = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;
    localparam logic [1:0] OP_PTR_RST = 2'd3;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [RW-1:0]       region_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     size_q;
    logic                done_q;
    logic                rd_pend;
    logic [DATA_W-1:0]   fifo_mem [2];
    logic                fifo_wp;
    logic                fifo_rp;
    logic [1:0]          fifo_cnt;
    logic [ADDR_W-1:0]   wr_head [NUM_REGIONS];
    logic [ADDR_W-1:0]   rd_head [NUM_REGIONS];

    logic [ADDR_W:0]     size_eff;
    logic [ADDR_W-1:0]   cur_wr;
    logic [ADDR_W-1:0]   cur_rd;
    logic [ADDR_W-1:0]   head_sel;
    logic [ADDR_W:0]     addr_sum;
    logic                beat;
    logic                pop;
    logic                issue;
    logic [1:0]          occ;
    logic                last_cnt;
    logic                wr_last;
    logic                rd_last;

    function automatic logic [ADDR_W-1:0] bump(
        input logic [ADDR_W-1:0] h,
        input logic [ADDR_W:0]   sz
    );
        logic [ADDR_W:0] nxt;
        nxt = {1'b0, h} + 1'b1;
        return (nxt == sz) ? '0 : nxt[ADDR_W-1:0];
    endfunction

    always_comb begin
        size_eff = (size_q == '0) ? DEPTH_V : size_q;
        cur_wr   = wr_head[region_q];
        cur_rd   = rd_head[region_q];
        head_sel = (state == READ) ? cur_rd : cur_wr;
        addr_sum = {1'b0, base_q} + {1'b0, head_sel};
        ram_addr_o = (addr_sum >= DEPTH_V) ? ADDR_W'(addr_sum - DEPTH_V)
                                           : ADDR_W'(addr_sum);

        cmd_ready_o     = (state == IDLE);
        busy_o          = (state != IDLE);
        ext_wr_ready_o  = (state == WRITE) && (op_q == OP_WR_EXT);
        obuf_wr_ready_o = (state == WRITE) && (op_q == OP_WR_OBUF);
        beat = (ext_wr_ready_o && ext_wr_valid_i)
            || (obuf_wr_ready_o && obuf_wr_valid_i);

        ram_wr_en_o   = beat;
        ram_wr_data_o = '0;
        if (beat)
            ram_wr_data_o = (op_q == OP_WR_OBUF) ? obuf_wr_data_i
                                                 : ext_wr_data_i;

        rd_valid_o = (fifo_cnt != 2'd0);
        pop        = rd_valid_o && rd_ready_i;
        rd_data_o  = rd_valid_o ? fifo_mem[fifo_rp] : '0;

        // a same-cycle pop frees a slot, which keeps reads back-to-back
        occ   = fifo_cnt + {1'b0, rd_pend};
        issue = (state == READ) && ((occ < 2'd2) || (pop && occ == 2'd2));
        ram_rd_en_o = issue;

        last_cnt = (cnt_q == len_q - 1'b1);
        wr_last  = beat && last_cnt;
        rd_last  = (state == DRAIN) && pop && (fifo_cnt == 2'd1) && !rd_pend;
        done_o   = done_q || wr_last || rd_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            region_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            size_q   <= '0;
            done_q   <= 1'b0;
            rd_pend  <= 1'b0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                wr_head[i] <= '0;
                rd_head[i] <= '0;
            end
        end else begin
            done_q  <= 1'b0;
            rd_pend <= issue;
            if (rd_pend) begin
                fifo_mem[fifo_wp] <= ram_rd_data_i;
                fifo_wp <= ~fifo_wp;
            end
            if (pop)
                fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};

            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q     <= cmd_op_i;
                        region_q <= cmd_region_i;
                        len_q    <= cmd_len_i;
                        cnt_q    <= '0;
                        base_q   <= cfg_base_i[cmd_region_i*ADDR_W +: ADDR_W];
                        size_q   <= cfg_size_i[cmd_region_i*(ADDR_W+1) +: ADDR_W+1];
                        if (cmd_op_i == OP_PTR_RST) begin
                            wr_head[cmd_region_i] <= '0;
                            rd_head[cmd_region_i] <= '0;
                            done_q <= 1'b1;
                        end else if (cmd_len_i == '0) begin
                            done_q <= 1'b1;
                        end else if (cmd_op_i == OP_READ) begin
                            state <= READ;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (beat) begin
                        wr_head[region_q] <= bump(cur_wr, size_eff);
                        cnt_q <= cnt_q + 1'b1;
                        if (last_cnt)
                            state <= IDLE;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_head[region_q] <= bump(cur_rd, size_eff);
                        cnt_q <= cnt_q + 1'b1;
                        if (last_cnt)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_last)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule
